// File: rtl/serial_frame_deserializer_pkg.sv
// Shared types and defaults for the serial frame deserializer.
package serial_frame_deserializer_pkg;

    // Frame-level FSM: look for sync, collect payload, check parity.
    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        PARITY  = 2'd2
    } deser_state_e;

    // Default sync word, transmitted MSB first.
    localparam int unsigned      DEFAULT_SYNC_WIDTH   = 4;
    localparam logic [3:0]       DEFAULT_SYNC_PATTERN = 4'b1011;

endpackage

// File: rtl/serial_frame_deserializer_out_stage.sv
// Output holding register with valid/ready handshake, overflow flag and
// a count of words loaded into the holding register.
module deser_out_stage #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  overflow_o,
    output logic [7:0]            count_o
);

    // Handshake: a word transfers on any cycle with valid_o=1 and ready_i=1.
    // data_o never changes while valid_o=1 and ready_i=0; a word that
    // arrives then is dropped and overflow is flagged until reset.
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  overflow_q;
    logic [7:0]            count_q;
    logic                  accept;
    logic                  can_load;

    assign accept   = valid_q & ready_i;
    assign can_load = ~valid_q | ready_i;

    // Holding register update: load, drop with overflow, or consume.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            count_q    <= '0;
        end else begin
            if (load_i && can_load) begin
                data_q  <= word_i;
                valid_q <= 1'b1;
                count_q <= count_q + 8'd1;
            end else begin
                if (load_i) begin
                    overflow_q <= 1'b1;
                end
                if (accept) begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign overflow_o = overflow_q;
    assign count_o    = count_q;

endmodule

// File: rtl/serial_frame_deserializer.sv
// Serial frame deserializer: hunts for a sync word, shifts in a payload MSB
// first, checks even parity and hands good words to the output stage.
module serial_frame_deserializer
    import serial_frame_deserializer_pkg::*;
#(
    parameter int unsigned                 SYNC_WIDTH   = DEFAULT_SYNC_WIDTH,
    parameter logic [SYNC_WIDTH-1:0]       SYNC_PATTERN = SYNC_WIDTH'(DEFAULT_SYNC_PATTERN),
    parameter int unsigned                 DATA_WIDTH   = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  shift_in,
    input  logic                  bit_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  parity_error,
    output logic                  overflow,
    output logic [7:0]            frame_count
);

    localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    deser_state_e          state_q;
    logic [SYNC_WIDTH-1:0] window_q;
    logic [SYNC_WIDTH-1:0] window_d;
    logic [DATA_WIDTH-1:0] payload_q;
    logic [DATA_WIDTH-1:0] payload_d;
    logic [CW-1:0]         bit_cnt_q;
    logic                  load_q;
    logic                  parity_error_q;
    logic                  parity_ok;
    logic                  last_bit;

    assign window_d  = {window_q[SYNC_WIDTH-2:0], shift_in};
    assign payload_d = {payload_q[DATA_WIDTH-2:0], shift_in};
    // Even parity over payload plus the parity bit itself.
    assign parity_ok = ~(^{payload_q, shift_in});
    assign last_bit  = (bit_cnt_q == CW'(DATA_WIDTH - 1));

    // Frame FSM with its shifters; load/parity_error are one-cycle pulses.
    // The payload register only moves in PAYLOAD, so it is still stable
    // in the cycle after the parity bit when the output stage loads it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= HUNT;
            window_q       <= '0;
            payload_q      <= '0;
            bit_cnt_q      <= '0;
            load_q         <= 1'b0;
            parity_error_q <= 1'b0;
        end else begin
            load_q         <= 1'b0;
            parity_error_q <= 1'b0;
            if (bit_en) begin
                case (state_q)
                    HUNT: begin
                        window_q <= window_d;
                        if (window_d == SYNC_PATTERN) begin
                            state_q   <= PAYLOAD;
                            bit_cnt_q <= '0;
                        end
                    end
                    PAYLOAD: begin
                        payload_q <= payload_d;
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                        if (last_bit) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        load_q         <= parity_ok;
                        parity_error_q <= ~parity_ok;
                        window_q       <= '0;
                        state_q        <= HUNT;
                    end
                    default: begin
                        window_q <= '0;
                        state_q  <= HUNT;
                    end
                endcase
            end
        end
    end

    assign parity_error = parity_error_q;

    deser_out_stage #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_stage (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_i     (load_q),
        .word_i     (payload_q),
        .ready_i    (data_ready),
        .data_o     (data_out),
        .valid_o    (data_valid),
        .overflow_o (overflow),
        .count_o    (frame_count)
    );

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Directed bench for serial_frame_deserializer with hand-computed expectations.
module tb_serial_frame_deserializer;

    logic       clock;
    logic       reset_n;
    logic       shift_in;
    logic       bit_en;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       parity_error;
    logic       overflow;
    logic [7:0] frame_count;

    int n_cmp;
    int n_bad;

    serial_frame_deserializer dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .shift_in     (shift_in),
        .bit_en       (bit_en),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .parity_error (parity_error),
        .overflow     (overflow),
        .frame_count  (frame_count)
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one sampled bit; returns 1 time unit after the sampling edge.
    task automatic send_bit(input logic b);
        @(negedge clock);
        shift_in = b;
        bit_en   = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            bit_en   = 1'b0;
            shift_in = 1'b0;
            @(posedge clock);
            #1;
        end
    endtask

    // Sync 1011, payload MSB first, then parity bit.
    task automatic send_frame(input logic [7:0] d, input logic p, input bit gap);
        logic [3:0] sync;
        sync = 4'b1011;
        for (int i = 3; i >= 0; i--) begin
            send_bit(sync[i]);
            if (gap) idle(1);
        end
        for (int i = 7; i >= 0; i--) begin
            send_bit(d[i]);
            if (gap && i != 0) idle(1);
        end
        if (gap) idle(1);
        send_bit(p);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        bit_en  = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".data_out"},     32'(data_out),     32'h0);
        check({tag, ".data_valid"},   32'(data_valid),   32'h0);
        check({tag, ".parity_error"}, 32'(parity_error), 32'h0);
        check({tag, ".overflow"},     32'(overflow),     32'h0);
        check({tag, ".frame_count"},  32'(frame_count),  32'h0);
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        reset_n    = 1'b0;
        shift_in   = 1'b0;
        bit_en     = 1'b0;
        data_ready = 1'b0;

        // Reset state
        #1;
        check_all_zero("reset");
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Basic good frame 5A, consumer always ready
        data_ready = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b0);
        check("basic.pending_valid", 32'(data_valid), 32'h0);
        check("basic.no_perr", 32'(parity_error), 32'h0);
        idle(1);
        check("basic.data_out", 32'(data_out), 32'h5A);
        check("basic.valid", 32'(data_valid), 32'h1);
        check("basic.count", 32'(frame_count), 32'h1);
        idle(1);
        check("basic.valid_cleared", 32'(data_valid), 32'h0);

        // Bad parity frame after a fresh reset
        do_reset();
        send_frame(8'h5A, 1'b1, 1'b0);
        check("perr.pulse", 32'(parity_error), 32'h1);
        idle(1);
        check("perr.pulse_ends", 32'(parity_error), 32'h0);
        check("perr.valid", 32'(data_valid), 32'h0);
        check("perr.count", 32'(frame_count), 32'h0);
        check("perr.overflow", 32'(overflow), 32'h0);

        // Leading junk that never forms the sync word
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_frame(8'h5A, 1'b0, 1'b0);
        idle(1);
        check("junk.data_out", 32'(data_out), 32'h5A);
        check("junk.valid", 32'(data_valid), 32'h1);
        check("junk.count", 32'(frame_count), 32'h1);
        idle(1);

        // Back-to-back frames with the consumer stalled -> overflow
        data_ready = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b0);
        idle(1);
        check("ovf.data_out_held", 32'(data_out), 32'h5A);
        check("ovf.valid", 32'(data_valid), 32'h1);
        check("ovf.flag", 32'(overflow), 32'h1);
        check("ovf.count", 32'(frame_count), 32'h2);

        // Reset during the 4th payload bit
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clock);
        shift_in = 1'b1;
        bit_en   = 1'b1;
        reset_n  = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clock);
        reset_n = 1'b1;
        bit_en  = 1'b0;
        // Tail of the aborted frame must not be mistaken for a sync word
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        idle(2);
        check("midreset.tail_ignored", 32'(data_valid), 32'h0);
        data_ready = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b0);
        idle(1);
        check("midreset.data_out", 32'(data_out), 32'h3C);
        check("midreset.valid", 32'(data_valid), 32'h1);
        check("midreset.count", 32'(frame_count), 32'h1);
        check("midreset.overflow", 32'(overflow), 32'h0);
        idle(1);

        // New word completes in the same cycle the held word is accepted
        data_ready = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b0);
        check("same.held_data", 32'(data_out), 32'h5A);
        data_ready = 1'b1;
        idle(1);
        check("same.data_out", 32'(data_out), 32'hC3);
        check("same.valid", 32'(data_valid), 32'h1);
        check("same.overflow", 32'(overflow), 32'h0);
        check("same.count", 32'(frame_count), 32'h3);
        data_ready = 1'b0;
        idle(2);
        check("same.stable_data", 32'(data_out), 32'hC3);
        check("same.stable_valid", 32'(data_valid), 32'h1);
        data_ready = 1'b1;
        idle(1);
        check("same.consumed", 32'(data_valid), 32'h0);

        // bit_en toggling every cycle
        send_frame(8'h5A, 1'b0, 1'b1);
        idle(1);
        check("toggle.data_out", 32'(data_out), 32'h5A);
        check("toggle.valid", 32'(data_valid), 32'h1);
        check("toggle.count", 32'(frame_count), 32'h4);
        idle(1);

        // frame_count wraps from 255 to 0
        for (int i = 0; i < 251; i++) begin
            send_frame(8'h81, 1'b0, 1'b0);
        end
        idle(1);
        check("wrap.count_255", 32'(frame_count), 32'hFF);
        check("wrap.data_out", 32'(data_out), 32'h81);
        idle(1);
        send_frame(8'hA7, 1'b1, 1'b0);
        idle(1);
        check("wrap.count_0", 32'(frame_count), 32'h0);
        check("wrap.data_out_a7", 32'(data_out), 32'hA7);
        check("wrap.overflow", 32'(overflow), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
